// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 raster constants, text-cell geometry and the aligned-signal bus type.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END = VS_START + V_SYNC;
  localparam int CELL = 8;
  localparam int TEXT_COLS = H_ACTIVE / CELL;
  localparam int TEXT_ROWS = V_ACTIVE / CELL;
  typedef struct packed {
    logic [2:0] xoff;
    logic [2:0] yoff;
    logic       hsync;
    logic       vsync;
    logic       video_on;
  } vga_pipe_t;
  localparam vga_pipe_t PIPE_IDLE = '{xoff: 3'd0, yoff: 3'd0, hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: enabled shift register of configurable width/depth with a synchronous reset value.
module vga_delay_line #(
  parameter int W = 1,
  parameter int DEPTH = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (DEPTH == 0) begin : g_pass
    assign q = d;
  end else begin : g_sr
    logic [DEPTH-1:0][W-1:0] sr;
    always_ff @(posedge clk) begin
      if (rst) begin
        sr <= {DEPTH{RST_VAL}};
      end else if (en) begin
        for (int i = DEPTH - 1; i > 0; i--) sr[i] <= sr[i-1];
        sr[0] <= d;
      end
    end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/vga_scan_timing.sv
// vga_scan_timing: raster counters, pixel strobe, position outputs and latency-aligned sync/blank/offsets.
module vga_scan_timing #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP = vga_pkg::V_BP,
  parameter int CLK_DIV = 2,
  parameter int PIPE_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] posx,
  output logic [9:0] posy,
  output logic [2:0] xoff,
  output logic [2:0] yoff,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);
  import vga_pkg::*;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div;
  logic [9:0] hcount, vcount, h_nxt, v_nxt;
  logic div_end, h_end, v_end;
  vga_pipe_t raw, dly;
  assign div_end = div == DW'(CLK_DIV - 1);
  assign pix_en = !rst && div_end;
  assign h_end = hcount == 10'(H_TOTAL - 1);
  assign v_end = vcount == 10'(V_TOTAL - 1);
  assign frame_start = pix_en && hcount == '0 && vcount == '0;
  always_comb begin
    h_nxt = pix_en ? (h_end ? '0 : hcount + 10'd1) : hcount;
    v_nxt = pix_en && h_end ? (v_end ? '0 : vcount + 10'd1) : vcount;
  end
  // posx/posy track the counters' next value so they stay aligned with hcount/vcount
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      hcount <= '0;
      vcount <= '0;
      posx <= '0;
      posy <= '0;
    end else begin
      div <= div_end ? '0 : div + 1'b1;
      hcount <= h_nxt;
      vcount <= v_nxt;
      posx <= h_nxt < 10'(H_ACTIVE) ? h_nxt : '0;
      posy <= v_nxt < 10'(V_ACTIVE) ? v_nxt : '0;
    end
  end
  always_comb begin
    raw.xoff = posx[2:0];
    raw.yoff = posy[2:0];
    raw.hsync = !(hcount >= 10'(H_ACTIVE + H_FP) && hcount < 10'(H_ACTIVE + H_FP + H_SYNC));
    raw.vsync = !(vcount >= 10'(V_ACTIVE + V_FP) && vcount < 10'(V_ACTIVE + V_FP + V_SYNC));
    raw.video_on = hcount < 10'(H_ACTIVE) && vcount < 10'(V_ACTIVE);
  end
  vga_delay_line #(.W($bits(vga_pipe_t)), .DEPTH(PIPE_LAT), .RST_VAL(PIPE_IDLE)) u_align (
    .clk(clk),
    .rst(rst),
    .en(pix_en),
    .d(raw),
    .q(dly)
  );
  assign {xoff, yoff, hsync, vsync, video_on} = dly;
endmodule

// File: doc/vga_scan_timing.md
Name: vga_scan_timing

Overview:
- Upstream timing stage for the text-mode VGA path.
- Generates the 640x480@60 raster: horizontal/vertical counters, sync pulses and blanking.
- Supplies pixel position (posx/posy) to the character-RAM address logic, and glyph offsets (xoff/yoff) to the glyph lookup.
- Delays offsets, syncs and blanking by a configurable number of pixel periods so they line up with the RAM/ROM read latency downstream.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel (>=1)
- PIPE_LAT, 1, pixel periods of alignment delay on xoff/yoff/hsync/vsync/video_on (>=0)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pix_en  out  1  one-clk strobe marking each pixel period
- posx  out  10  current column, 0..H_ACTIVE-1; 0 outside active area (undelayed, feeds address calc)
- posy  out  10  current line, 0..V_ACTIVE-1; 0 outside active area (undelayed)
- xoff  out  3  posx[2:0], delayed PIPE_LAT pixels
- yoff  out  3  posy[2:0], delayed PIPE_LAT pixels
- hsync  out  1  horizontal sync, active-low, delayed PIPE_LAT
- vsync  out  1  vertical sync, active-low, delayed PIPE_LAT
- video_on  out  1  high in active area, delayed PIPE_LAT
- frame_start  out  1  one-clk pulse coinciding with pix_en when hcount=0 and vcount=0 (undelayed)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Internal hcount/vcount are 10 bits.
- Divider:
  - Counts 0..CLK_DIV-1; pix_en=1 when divider = CLK_DIV-1.
  - CLK_DIV=1: pix_en is constantly 1 after reset.
- Counters advance only on pix_en:
  - hcount wraps H_TOTAL-1 -> 0.
  - On that wrap, vcount increments, wrapping V_TOTAL-1 -> 0.
  - Simultaneous end-of-line and end-of-frame: both wrap in the same cycle.
- Raw (undelayed) signals, from the registered counters:
  - hsync_raw = 0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync_raw = 0 iff 490 <= vcount < 492.
  - active = hcount<H_ACTIVE && vcount<V_ACTIVE.
- posx/posy:
  - posx = hcount while hcount<H_ACTIVE, else 0; posy likewise with vcount.
  - Both are registered outputs updated with the counters; zeroing keeps downstream address < 80*60.
- Alignment pipeline:
  - PIPE_LAT-deep shift register per signal (xoff, yoff, hsync, vsync, video_on).
  - Shifts only on pix_en; holds otherwise.
  - PIPE_LAT=0: outputs equal raw values.
- frame_start is a combinational AND of pix_en and counters at 0,0. It is not delayed.
- Reset, applied any cycle including mid-frame:
  - divider=0, hcount=0, vcount=0; posx=posy=0.
  - All pipeline stages set to hsync=1, vsync=1, video_on=0, xoff=yoff=0.
  - pix_en=0 during the reset cycle; frame_start=0.
  - The first pix_en after release comes CLK_DIV-1 cycles after rst deasserts.
  - The first frame_start occurs on that first pix_en.
- No output glitches: every output except pix_en and frame_start comes directly from a flop.

Decomposition:
- Package vga_pkg:
  - Timing constants and derived H_TOTAL/V_TOTAL.
  - Sync and blank boundaries.
  - Character cell size (8), text columns (80) and rows (60).
  - Shared with the address and glyph stages.
- Sub-module: vga_delay_line, a parameterised width/depth shift register with enable and synchronous reset value. Instantiated once on the packed {xoff, yoff, hsync, vsync, video_on} bus.

Test Plan:
- Reset release, CLK_DIV=2 -> pix_en pulses every 2nd clk; frame_start on first pix_en; posx=posy=0; hsync=vsync=1; video_on=0.
- Run one line -> hsync low exactly 96 pixel periods, starting at hcount 656+PIPE_LAT; video_on high 640 periods; posx 0..639 then held 0 for 160 periods.
- Run full frame -> frame_start period 840000 clks; vsync low for 2 lines (1600 pixel periods) starting at line 490; posy holds 0 for lines 480..524.
- Alignment, PIPE_LAT=1 -> xoff at pixel (13,_) equals 5 one pixel period after posx=13; yoff changes one pixel after posy at line boundaries.
- Assert rst mid-frame (hcount=400, vcount=300) for 1 clk -> next cycle all counters and outputs at reset values; raster restarts from 0,0 with frame_start.
- Corners: CLK_DIV=1, PIPE_LAT=0 -> pix_en constant high; hsync falls in the same clk hcount reaches 656; wrap at (799,524) -> (0,0) in one step.
